// File: rtl/mcb_cmd_arbiter_pkg.sv
// Shared types and constants for the MCB command-port arbiter.
package mcb_arb_pkg;

  localparam logic [2:0] WR    = 3'b000;
  localparam logic [2:0] RD    = 3'b001;
  localparam logic [2:0] WR_AP = 3'b010;
  localparam logic [2:0] RD_AP = 3'b011;
  localparam logic [2:0] REF   = 3'b100;

  typedef enum logic [1:0] {WAIT_CAL, ARB, ISSUE} arb_state_t;

  // Index width for n items; never below 1 so a 1-bit index always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mcb_cmd_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int c;

  // Walk the offsets from farthest to nearest so the nearest hit lands last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mcb_cmd_arbiter.sv
// Round-robin sharing of one MCB command port, gated on PLL lock and calibration.
module mcb_cmd_arbiter import mcb_arb_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 30,
  parameter int BL_W         = 6,
  parameter int MAX_BURST    = 8,
  parameter int STARTUP_WAIT = 16
)(
  input  logic                        clk0_bufg,
  input  logic                        sys_rst,
  input  logic                        pll_lock,
  input  logic                        calib_done,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [3*NUM_REQ-1:0]        req_instr,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [BL_W*NUM_REQ-1:0]     req_bl,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        p_cmd_full,
  output logic                        p_cmd_en,
  output logic [2:0]                  p_cmd_instr,
  output logic [ADDR_W-1:0]           p_cmd_addr,
  output logic [BL_W-1:0]             p_cmd_bl,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        granted,
  output logic                        ready_o
);

  localparam int         IDX_W   = clog2(NUM_REQ);
  localparam logic [7:0] MB_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] SW_LAST = 8'(STARTUP_WAIT - 1);

  arb_state_t       state;
  logic [1:0]       sync_ff;
  logic             ok;
  logic [IDX_W-1:0] rr_ptr, rr_nxt, pick_idx;
  logic             pick_found;
  logic [7:0]       burst_cnt, start_cnt;
  logic             xfer, release_g;

  logic [2:0]        instr_a [NUM_REQ];
  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [BL_W-1:0]   bl_a    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign instr_a[g] = req_instr[3*g +: 3];
    assign addr_a[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign bl_a[g]    = req_bl[BL_W*g +: BL_W];
  end

  always_ff @(posedge clk0_bufg or posedge sys_rst)
    if (sys_rst) sync_ff <= '0;
    else         sync_ff <= {sync_ff[0], pll_lock};

  assign ok = sync_ff[1] && calib_done;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req_valid), .ptr(rr_ptr), .found(pick_found), .idx(pick_idx)
  );

  // Folding ok into the issue qualifier blocks a transfer in the cycle lock is lost.
  always_comb begin
    req_ready = '0;
    if (state == ISSUE && ok && !p_cmd_full) req_ready[grant_id] = 1'b1;
  end

  assign xfer      = req_valid[grant_id] && req_ready[grant_id];
  assign p_cmd_en  = xfer;
  assign release_g = (state == ISSUE) &&
                     ((xfer && burst_cnt == MB_LAST) || (!req_valid[grant_id] && !p_cmd_full));
  assign rr_nxt    = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    p_cmd_instr = '0;
    p_cmd_addr  = '0;
    p_cmd_bl    = '0;
    if (granted) begin
      p_cmd_instr = instr_a[grant_id];
      p_cmd_addr  = addr_a[grant_id];
      p_cmd_bl    = bl_a[grant_id];
    end
  end

  always_ff @(posedge clk0_bufg or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= WAIT_CAL;
      grant_id  <= '0;
      granted   <= 1'b0;
      ready_o   <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      start_cnt <= '0;
    end else if (!ok && state != WAIT_CAL) begin
      // rr_ptr survives so fairness picks up where it left off after relock.
      state     <= WAIT_CAL;
      granted   <= 1'b0;
      ready_o   <= 1'b0;
      burst_cnt <= '0;
      start_cnt <= '0;
    end else begin
      case (state)
        WAIT_CAL: begin
          if (!ok) start_cnt <= '0;
          else if (start_cnt == SW_LAST) begin
            state     <= ARB;
            ready_o   <= 1'b1;
            start_cnt <= '0;
          end else start_cnt <= start_cnt + 8'd1;
        end
        ARB: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            granted   <= 1'b1;
            burst_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (release_g) begin
            granted   <= 1'b0;
            rr_ptr    <= rr_nxt;
            burst_cnt <= '0;
            state     <= ARB;
          end else if (xfer) burst_cnt <= burst_cnt + 8'd1;
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Bench for mcb_cmd_arbiter: directed tables and sequences plus random traffic vs a model.
module tb_mcb_cmd_arbiter;
  import mcb_arb_pkg::*;

  localparam int N = 4, AW = 30, BW = 6, MB = 4, SW = 16;
  localparam int START_TICKS = SW + 3;

  logic clk0_bufg = 1'b0, sys_rst = 1'b1, pll_lock = 1'b0, calib_done = 1'b0, p_cmd_full = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [3*N-1:0]  req_instr;
  logic [AW*N-1:0] req_addr;
  logic [BW*N-1:0] req_bl;
  logic            p_cmd_en, granted, ready_o;
  logic [2:0]      p_cmd_instr;
  logic [AW-1:0]   p_cmd_addr;
  logic [BW-1:0]   p_cmd_bl;
  logic [1:0]      grant_id;

  logic [2:0]    instr_a [N];
  logic [AW-1:0] addr_a  [N];
  logic [BW-1:0] bl_a    [N];

  always #5 clk0_bufg = ~clk0_bufg;

  always_comb begin
    req_instr = '0; req_addr = '0; req_bl = '0;
    for (int i = 0; i < N; i++) begin
      req_instr[3*i +: 3]  = instr_a[i];
      req_addr[AW*i +: AW] = addr_a[i];
      req_bl[BW*i +: BW]   = bl_a[i];
    end
  end

  mcb_cmd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .BL_W(BW), .MAX_BURST(MB), .STARTUP_WAIT(SW)) dut (
    .clk0_bufg(clk0_bufg), .sys_rst(sys_rst), .pll_lock(pll_lock), .calib_done(calib_done),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr), .req_bl(req_bl),
    .req_ready(req_ready), .p_cmd_full(p_cmd_full), .p_cmd_en(p_cmd_en),
    .p_cmd_instr(p_cmd_instr), .p_cmd_addr(p_cmd_addr), .p_cmd_bl(p_cmd_bl),
    .grant_id(grant_id), .granted(granted), .ready_o(ready_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: lock history, startup run length, current owner, next priority start.
  bit ls1, ls2, m_rdy;
  int m_cnt, m_owner, m_gid, m_burst, m_next;

  task automatic model_reset();
    ls1 = 0; ls2 = 0; m_rdy = 0; m_cnt = 0; m_owner = -1; m_gid = 0; m_burst = 0; m_next = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    logic [2:0] ei; logic [AW-1:0] ea; logic [BW-1:0] eb;
    bit lk;
    lk = ls2 && calib_done;
    er = '0; ei = '0; ea = '0; eb = '0;
    if (m_owner >= 0) begin
      if (lk && !p_cmd_full) er[m_owner] = 1'b1;
      ei = instr_a[m_owner]; ea = addr_a[m_owner]; eb = bl_a[m_owner];
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("p_cmd_en", 64'(p_cmd_en), 64'(|(er & req_valid)));
    chk("granted", 64'(granted), 64'(m_owner >= 0));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("ready_o", 64'(ready_o), 64'(m_rdy));
    chk("p_cmd_instr", 64'(p_cmd_instr), 64'(ei));
    chk("p_cmd_addr", 64'(p_cmd_addr), 64'(ea));
    chk("p_cmd_bl", 64'(p_cmd_bl), 64'(eb));
  endtask

  task automatic model_step();
    bit lk, en, rel;
    int c;
    lk = ls2 && calib_done;
    en = (m_owner >= 0) && lk && !p_cmd_full && req_valid[m_owner];
    rel = 0;
    if (!lk) begin
      m_cnt = 0;
      if (m_rdy) begin m_rdy = 0; m_owner = -1; m_burst = 0; end
    end else if (!m_rdy) begin
      if (m_cnt == SW - 1) begin m_rdy = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_next + k) % N;
        if (req_valid[c]) begin m_owner = c; m_gid = c; m_burst = 0; break; end
      end
    end else if (en) begin
      m_burst++;
      rel = (m_burst == MB);
    end else rel = !req_valid[m_owner] && !p_cmd_full;
    if (rel) begin m_next = (m_owner + 1) % N; m_owner = -1; m_burst = 0; end
    ls2 = ls1; ls1 = pll_lock;
  endtask

  task automatic rnd_fields();
    for (int i = 0; i < N; i++) begin
      instr_a[i] = 3'($urandom_range(0, 4));
      addr_a[i]  = AW'($urandom);
      bl_a[i]    = BW'($urandom);
    end
  endtask

  // One clock: drive at negedge, compare just after, then advance the model for the posedge.
  task automatic tick(input logic [N-1:0] v, input logic f, input logic lk, input logic cal, input bit rf);
    @(negedge clk0_bufg);
    req_valid = v; p_cmd_full = f; pll_lock = lk; calib_done = cal;
    if (rf) rnd_fields();
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic wait_ready(input logic [N-1:0] v, output int n);
    n = 0;
    do begin
      tick(v, 1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end while (!ready_o && n < 200);
  endtask

  task automatic do_reset();
    @(negedge clk0_bufg);
    #2 sys_rst = 1'b1;
    pll_lock = 1'b0; calib_done = 1'b0; req_valid = '0; p_cmd_full = 1'b0;
    model_reset();
    #1;
    chk("rst_en", 64'(p_cmd_en), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_granted", 64'(granted), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_fields", 64'({p_cmd_instr, p_cmd_addr, p_cmd_bl}), 64'd0);
    @(posedge clk0_bufg);
    @(posedge clk0_bufg);
    #2 sys_rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         f;
    logic         en;
    logic         gr;
    int           gid;
  } vec_t;

  vec_t tbl[$];
  int n;

  initial begin
    // Round-robin under full contention: MB commands per owner, one dead ARB cycle between.
    for (int o = 0; o < N; o++) begin
      for (int b = 0; b < MB; b++) tbl.push_back('{v: 4'b1111, f: 1'b0, en: 1'b1, gr: 1'b1, gid: o});
      tbl.push_back('{v: 4'b1111, f: 1'b0, en: 1'b0, gr: 1'b0, gid: o});
    end
    tbl.push_back('{v: 4'b1111, f: 1'b0, en: 1'b1, gr: 1'b1, gid: 0});

    rnd_fields();
    model_reset();
    #12 sys_rst = 1'b0;
    @(posedge clk0_bufg);
    #2;

    // Cold start with all requesters waiting.
    wait_ready(4'b1111, n);
    chk("startup_len", 64'(n), 64'(START_TICKS));
    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].f, 1'b1, 1'b1, 1'b0);
      chk("rr_en", 64'(p_cmd_en), 64'(tbl[i].en));
      chk("rr_granted", 64'(granted), 64'(tbl[i].gr));
      chk("rr_gid", 64'(grant_id), 64'(tbl[i].gid));
    end

    // Backpressure: grant held while full, then a full burst resumes.
    do_reset();
    wait_ready(4'b0000, n);
    tick(4'b0010, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0010, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("bp_en", 64'(p_cmd_en), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_hold", 64'({granted, grant_id}), 64'({1'b1, 2'd1}));
    end
    for (int i = 0; i < MB; i++) begin
      tick(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("bp_resume", 64'(p_cmd_en), 64'd1);
    end
    tick(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp_rotate", 64'({p_cmd_en, granted}), 64'd0);

    // Early release by owner 2; pointer then favours 3 over 0.
    do_reset();
    wait_ready(4'b0000, n);
    tick(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("er_issue", 64'({p_cmd_en, grant_id}), 64'({1'b1, 2'd2}));
    end
    tick(4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("er_idle", 64'({p_cmd_en, granted}), 64'({1'b0, 1'b1}));
    tick(4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("er_arb", 64'(granted), 64'd0);
    tick(4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("er_ptr3", 64'({p_cmd_en, grant_id}), 64'({1'b1, 2'd3}));
    tick(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("er_to0", 64'({p_cmd_en, grant_id}), 64'({1'b1, 2'd0}));

    // Lock loss mid-burst, relock wait, then async reset mid-issue.
    do_reset();
    wait_ready(4'b0001, n);
    tick(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ll_sync1", 64'(p_cmd_en), 64'd1);
    tick(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ll_block", 64'({p_cmd_en, req_ready}), 64'd0);
    tick(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ll_waitcal", 64'({ready_o, granted}), 64'd0);
    wait_ready(4'b0001, n);
    chk("relock_len", 64'(n), 64'(START_TICKS));
    tick(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_issue", 64'(p_cmd_en), 64'd1);
    do_reset();
    wait_ready(4'b0001, n);
    chk("rst_restart_len", 64'(n), 64'(START_TICKS));

    // Random traffic, backpressure and occasional lock/calibration drops.
    for (int i = 0; i < 1500; i++)
      tick(N'($urandom), ($urandom % 4) == 0, ($urandom % 60) != 0, ($urandom % 60) != 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
